// File: rtl/k005297_pkg.sv
// Shared types and defaults for the k005297 byte acquisition sequencer.
// States, byte-count width, output bundle and slot-mask helper.
package k005297_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_BYTEEND,
    S_WAIT,
    S_FIN
  } state_e;

  localparam int CNT_W          = 8;
  localparam int PAGE_BYTES_DEF = 64;
  localparam int BIT_SLOT_DEF   = 3;
  localparam int TIMEOUT_DEF    = 4096;

  typedef struct packed {
    logic act_n;
    logic newbyte;
    logic glcnt;
    logic bubwr;
    logic stb;
    logic ack;
    logic done;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{
    act_n:   1'b1,
    default: 1'b0
  };

  function automatic logic [19:0] slot_mask(input int slot);
    return 20'd1 << slot;
  endfunction

endpackage

// File: rtl/k005297_byteacq_seq_if.sv
// Transfer requester handshake for the byte acquisition sequencer.
// master = page-transfer controller, slave = sequencer.
interface k005297_byteacq_seq_if;

  logic i_XFER_REQ;
  logic i_XFER_WR;
  logic o_XFER_ACK;
  logic o_XFER_DONE;
  logic o_XFER_ERR;

  modport master (
    output i_XFER_REQ,
    output i_XFER_WR,
    input  o_XFER_ACK,
    input  o_XFER_DONE,
    input  o_XFER_ERR
  );

  modport slave (
    input  i_XFER_REQ,
    input  i_XFER_WR,
    output o_XFER_ACK,
    output o_XFER_DONE,
    output o_XFER_ERR
  );

endinterface

// File: rtl/k005297_byteacq_wdt.sv
// Stall watchdog: counts enable ticks without progress while active.
// Built only when K005297_BYTEACQ_WDT_EN is defined.
`ifdef K005297_BYTEACQ_WDT_EN
module k005297_byteacq_wdt #(
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic active,
  input  logic progress,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_TICKS + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         idle_tick;

  assign idle_tick = tick & active & ~progress;
  assign expire    = idle_tick &
                     (cnt_q == W'(TIMEOUT_TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = idle_tick ? cnt_q + W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/k005297_byteacq_seq.sv
// Byte acquisition sequencer: arms, strobes and collects one page of bytes.
// Optional stall watchdog: define K005297_BYTEACQ_WDT_EN.
module k005297_byteacq_seq
  import k005297_pkg::*;
#(
  parameter int PAGE_BYTES    = PAGE_BYTES_DEF,
  parameter int BIT_SLOT      = BIT_SLOT_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_DEF
) (
  input  logic                  i_MCLK,
  input  logic                  i_RST_n,
  input  logic                  i_CLK2M_PCEN_n,
  input  logic [19:0]           i_ROT20_n,
  k005297_byteacq_seq_if.slave  xfer,
  input  logic                  i_FIFO_RDY,
  input  logic                  i_BYTEACQ_DONE,
  output logic                  o_ACC_ACT_n,
  output logic                  o_NEWBYTE,
  output logic                  o_GLCNT_RD,
  output logic                  o_BUBWR_WAIT,
  output logic                  o_BYTE_STB,
  output logic [CNT_W-1:0]      o_BYTE_CNT
);

  state_e           state_q, state_d;
  seq_out_t         out_q, out_d;
  logic             wr_q, wr_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tick;
  logic             slot_hit;
  logic             req;
  logic             expire;

  assign tick     = ~i_CLK2M_PCEN_n;
  assign slot_hit = |(~i_ROT20_n & slot_mask(BIT_SLOT));
  assign req      = xfer.i_XFER_REQ;
  assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef K005297_BYTEACQ_WDT_EN
  logic active;
  logic progress;
  logic err_q, err_d;

  assign active   = (state_q == S_SHIFT) |
                    (state_q == S_WAIT);
  assign progress = ((state_q == S_SHIFT) & slot_hit) |
                    ((state_q == S_WAIT) & i_FIFO_RDY);

  k005297_byteacq_wdt #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_wdt (
    .clk      (i_MCLK),
    .rst_n    (i_RST_n),
    .tick     (tick),
    .active   (active),
    .progress (progress),
    .expire   (expire)
  );

  always_comb begin
    err_d = err_q;
    if (tick) begin
      if (state_q == S_IDLE && req) begin
        err_d = 1'b0;
      end else if (expire) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign xfer.o_XFER_ERR = err_q;
`else
  assign expire          = 1'b0;
  assign xfer.o_XFER_ERR = (TIMEOUT_TICKS < 0);
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    wr_d    = wr_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    if (tick) begin
      out_d.newbyte = 1'b0;
      out_d.glcnt   = 1'b0;
      out_d.stb     = 1'b0;
      out_d.ack     = 1'b0;
      out_d.done    = 1'b0;
      // abort wins over every in-flight action
      if (state_q != S_IDLE && (!req || expire)) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (req) begin
              wr_d      = xfer.i_XFER_WR;
              cnt_d     = '0;
              out_d.ack = 1'b1;
              state_d   = S_ARM;
            end
          end
          S_ARM: begin
            out_d.newbyte = 1'b1;
            seen_d        = 1'b0;
            state_d       = S_SHIFT;
          end
          S_SHIFT: begin
            if (i_BYTEACQ_DONE && seen_q) begin
              state_d = S_BYTEEND;
            end else if (slot_hit) begin
              out_d.glcnt = 1'b1;
              seen_d      = 1'b1;
            end
          end
          S_BYTEEND: begin
            out_d.stb = 1'b1;
            cnt_d     = cnt_inc;
            if (cnt_inc == CNT_W'(PAGE_BYTES)) begin
              state_d = S_FIN;
            end else if (i_FIFO_RDY) begin
              state_d = S_ARM;
            end else begin
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            if (i_FIFO_RDY) begin
              state_d = S_ARM;
            end
          end
          S_FIN: begin
            out_d.done = 1'b1;
            state_d    = S_IDLE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
      out_d.act_n = (state_d == S_IDLE);
      out_d.bubwr = (state_d == S_WAIT) && wr_q;
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= S_IDLE;
      out_q   <= OUT_RST;
      wr_q    <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      wr_q    <= wr_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ACC_ACT_n      = out_q.act_n;
  assign o_NEWBYTE        = out_q.newbyte;
  assign o_GLCNT_RD       = out_q.glcnt;
  assign o_BUBWR_WAIT     = out_q.bubwr;
  assign o_BYTE_STB       = out_q.stb;
  assign o_BYTE_CNT       = cnt_q;
  assign xfer.o_XFER_ACK  = out_q.ack;
  assign xfer.o_XFER_DONE = out_q.done;

endmodule

// File: tb/tb_k005297_byteacq_seq.sv
// Bench for k005297_byteacq_seq: page transfers against a page-level model.
// Watchdog checks run when K005297_BYTEACQ_WDT_EN is defined.
module tb_k005297_byteacq_seq;
  import k005297_pkg::*;

  localparam int PB       = 4;
  localparam int SLOT     = 3;
  localparam int TO       = 64;
  localparam int ACQ_BITS = 8;

  logic        mclk   = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pcen_n = 1'b1;
  logic [19:0] rot;
  logic        fifo_rdy   = 1'b1;
  logic        force_done = 1'b0;
  logic        acq_done;
  logic        acc_act_n, newbyte, glcnt, bubwr, stb;
  logic [7:0]  cnt;
  int          acq    = 0;
  int          tcount = 0;
  int          phase0 = 0;
  bit          hit_at_tick;
  int          errors = 0;
  int          checks = 0;

  k005297_byteacq_seq_if xif();

  k005297_byteacq_seq #(
    .PAGE_BYTES    (PB),
    .BIT_SLOT      (SLOT),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .i_MCLK         (mclk),
    .i_RST_n        (rst_n),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_ROT20_n      (rot),
    .xfer           (xif),
    .i_FIFO_RDY     (fifo_rdy),
    .i_BYTEACQ_DONE (acq_done),
    .o_ACC_ACT_n    (acc_act_n),
    .o_NEWBYTE      (newbyte),
    .o_GLCNT_RD     (glcnt),
    .o_BUBWR_WAIT   (bubwr),
    .o_BYTE_STB     (stb),
    .o_BYTE_CNT     (cnt)
  );

  always #5 mclk = ~mclk;

  assign rot      = ~(20'd1 << ((phase0 + tcount) % 20));
  assign acq_done = (acq >= ACQ_BITS) || force_done;

  // enable every other edge; slots and the acquisition counter advance per tick
  always @(negedge mclk) begin
    if (!pcen_n) begin
      tcount = tcount + 1;
      if (newbyte) acq = 0;
      else if (glcnt && acq < 255) acq = acq + 1;
    end
    pcen_n = ~pcen_n;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk iff !pcen_n);
    hit_at_tick = !rot[SLOT];
    #1;
  endtask

  task automatic run_page(input bit wr, input int sb,
                          input int slen, input bit hold,
                          input int ab, input int ab_after);
    int  exp_glc, exp_bw, glc, bw, n;
    bit  ok;
    exp_glc = hold ? 1 : ACQ_BITS;
    exp_bw  = wr ? slen + 1 : 0;
    xif.i_XFER_WR  = wr;
    fifo_rdy       = 1'b1;
    force_done     = hold;
    xif.i_XFER_REQ = 1'b1;
    step();
    chk("ack", xif.o_XFER_ACK, 1);
    chk("cnt_clr", cnt, 0);
    chk("err_clr", xif.o_XFER_ERR, 0);
    chk("act_on", acc_act_n, 0);
    for (int b = 1; b <= PB; b++) begin
      n = 0;
      do begin step(); n++; end
      while (!newbyte && n < 8);
      if (!newbyte) begin
        chk("newbyte_timeout", 0, 1);
        return;
      end
      if (b == sb) fifo_rdy = 1'b0;
      glc = 0; n = 0; ok = 0;
      while (n < 400) begin
        step(); n++;
        if (glcnt) begin
          glc++;
          chk("slot", hit_at_tick, 1);
        end
        if (stb) begin ok = 1; break; end
        if (b == ab && glc == ab_after) begin
          xif.i_XFER_REQ = 1'b0;
          step();
          chk("abort_act", acc_act_n, 1);
          chk("abort_cnt", cnt, b - 1);
          bw = 0;
          for (int i = 0; i < 30; i++) begin
            step();
            if (xif.o_XFER_DONE || glcnt || newbyte) bw++;
          end
          chk("abort_quiet", bw, 0);
          chk("abort_hold", cnt, b - 1);
          return;
        end
      end
      if (!ok) begin
        chk("stb_timeout", 0, 1);
        return;
      end
      chk("byte_cnt", cnt, b);
      chk("glc_per_byte", glc, exp_glc);
      if (b == sb) begin
        bw = bubwr; glc = 0;
        for (int i = 0; i < slen; i++) begin
          step();
          bw += bubwr;
          glc += glcnt;
        end
        chk("wait_act", acc_act_n, 0);
        fifo_rdy = 1'b1;
        step();
        bw += bubwr;
        chk("wait_bubwr", bw, exp_bw);
        chk("wait_glc", glc, 0);
      end
    end
    n = 0;
    do begin step(); n++; end
    while (!xif.o_XFER_DONE && n < 4);
    chk("done", xif.o_XFER_DONE, 1);
    chk("done_lat", n, 1);
    chk("fin_act", acc_act_n, 1);
    chk("fin_cnt", cnt, PB);
    xif.i_XFER_REQ = 1'b0;
    step();
    chk("done_pulse", xif.o_XFER_DONE, 0);
  endtask

  initial begin
    int n;
    phase0         = $urandom_range(0, 19);
    xif.i_XFER_REQ = 1'b0;
    xif.i_XFER_WR  = 1'b0;
    repeat (4) @(posedge mclk);
    #1;
    chk("rst_act", acc_act_n, 1);
    chk("rst_nb", newbyte, 0);
    chk("rst_glc", glcnt, 0);
    chk("rst_bw", bubwr, 0);
    chk("rst_stb", stb, 0);
    chk("rst_ack", xif.o_XFER_ACK, 0);
    chk("rst_done", xif.o_XFER_DONE, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_err", xif.o_XFER_ERR, 0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_act", acc_act_n, 1);

    run_page(0, 0, 0, 0, 0, 0);
    run_page(1, 2, 50, 0, 0, 0);
    run_page(0, 1, 30, 0, 0, 0);
    run_page(0, 0, 0, 1, 0, 0);
    run_page(1, 0, 0, 0, 3, 3);
    run_page(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      run_page(1'($urandom_range(0, 1)),
               $urandom_range(0, PB - 1),
               $urandom_range(3, 60), 0, 0, 0);
    end

`ifdef K005297_BYTEACQ_WDT_EN
    xif.i_XFER_WR  = 1'b1;
    fifo_rdy       = 1'b1;
    force_done     = 1'b0;
    xif.i_XFER_REQ = 1'b1;
    n = 0;
    do begin step(); n++; end
    while (!newbyte && n < 8);
    fifo_rdy = 1'b0;
    n = 0;
    do begin step(); n++; end
    while (!stb && n < 400);
    chk("wdt_stb", stb, 1);
    n = 0;
    while (!xif.o_XFER_ERR && n < 4 * TO) begin
      step(); n++;
    end
    xif.i_XFER_REQ = 1'b0;
    chk("wdt_ticks", n, TO);
    chk("wdt_act", acc_act_n, 1);
    chk("wdt_bw", bubwr, 0);
    repeat (3) step();
    chk("wdt_sticky", xif.o_XFER_ERR, 1);
    fifo_rdy = 1'b1;
    run_page(0, 0, 0, 0, 0, 0);
`else
    run_page(1, 1, 200, 0, 0, 0);
`endif

    xif.i_XFER_WR  = 1'b1;
    fifo_rdy       = 1'b1;
    force_done     = 1'b0;
    xif.i_XFER_REQ = 1'b1;
    n = 0;
    do begin step(); n++; end
    while (!stb && n < 400);
    chk("pre_rst_cnt", cnt, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_act", acc_act_n, 1);
    chk("arst_cnt", cnt, 0);
    chk("arst_ack", xif.o_XFER_ACK, 0);
    xif.i_XFER_REQ = 1'b0;
    #20 rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_act", acc_act_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
